// File: rtl/comm_pkg.sv
// ---------------------------------------------------------------------------
// comm_pkg
// Shared definitions for the framed word parser: default sync pattern,
// default payload depth, the parser state encoding and a small helper that
// sizes address counters for a given payload depth.
// ---------------------------------------------------------------------------
package comm_pkg;

   localparam logic [15:0] COMM_SYNC    = 16'hC0DE;
   localparam int          COMM_MAX_LEN = 8;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2,
      DRAIN   = 2'd3
   } comm_state_t;

   // Width of an index able to address every payload slot (at least 1 bit)
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/comm_frame_buf.sv
// ---------------------------------------------------------------------------
// comm_frame_buf
// Payload store for one frame: DEPTH x 32-bit registers with a single
// synchronous write port and a single asynchronous read port. Contents are
// deliberately not reset; a frame is always written before it is read.
//
// Ports:
//   clk      - system clock
//   wr_en    - write strobe
//   wr_addr  - write slot
//   wr_data  - word to store
//   rd_addr  - read slot
//   rd_data  - word held in rd_addr (combinational)
// ---------------------------------------------------------------------------
module comm_frame_buf #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);

   logic [31:0] mem [DEPTH];

   // Plain register file write; no reset so stale payload simply gets overwritten
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/comm_frame_parser.sv
// ---------------------------------------------------------------------------
// comm_frame_parser
// Parses frames out of a stream of 32-bit words: header (sync, seq, len),
// len payload words, then an XOR checksum word covering header and payload.
// Good frames are drained downstream with a valid/ready handshake; bad
// headers, bad checksums and words arriving while draining are counted.
//
// Ports:
//   CLK          - system clock, rising edge
//   RST          - asynchronous active-low reset
//   word_valid_i - word-ready level from the serial collector (edge detected)
//   word_i       - collected word
//   out_ready_i  - downstream accepts out_data_o
//   out_valid_o  - out_data_o holds a payload word
//   out_data_o   - payload word
//   out_last_o   - final payload word of the frame
//   out_seq_o    - sequence number of the frame being drained
//   frame_ok_o   - one-cycle pulse on checksum pass
//   frame_err_o  - one-cycle pulse on any frame error
//   err_count_o  - saturating error counter
// ---------------------------------------------------------------------------
module comm_frame_parser
   import comm_pkg::*;
#(
   parameter logic [15:0] SYNC    = COMM_SYNC,
   parameter int          MAX_LEN = COMM_MAX_LEN
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        word_valid_i,
   input  logic [31:0] word_i,
   input  logic        out_ready_i,
   output logic        out_valid_o,
   output logic [31:0] out_data_o,
   output logic        out_last_o,
   output logic [7:0]  out_seq_o,
   output logic        frame_ok_o,
   output logic        frame_err_o,
   output logic [7:0]  err_count_o
);

   localparam int         IDX_W    = idx_width(MAX_LEN);
   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   comm_state_t      state, state_next;
   logic             prev_valid;
   logic [IDX_W-1:0] idx, idx_next;
   logic [IDX_W-1:0] rd, rd_next;
   logic [7:0]       len, len_next;
   logic [7:0]       seq, seq_next;
   logic [31:0]      csum, csum_next;
   logic [7:0]       err_count, err_count_next;
   logic             frame_ok, ok_next;
   logic             frame_err, err_next;
   logic             drain_live, drain_live_next;
   logic             buf_wr;
   logic             err_bump;
   logic             accept;
   logic             xfer;
   logic             rd_is_last;
   logic [31:0]      rd_data;

   // One accept per rising edge of the upstream level, however long it is held
   assign accept     = word_valid_i & ~prev_valid;
   assign rd_is_last = (8'(rd) == (len - 8'd1));
   assign xfer       = out_valid_o & out_ready_i;

   comm_frame_buf #(
      .DEPTH (MAX_LEN),
      .AW    (IDX_W)
   ) payload_store (
      .clk     (CLK),
      .wr_en   (buf_wr),
      .wr_addr (idx),
      .wr_data (word_i),
      .rd_addr (rd),
      .rd_data (rd_data)
   );

   // State and datapath registers; the buffer itself is left untouched by reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= HUNT;
         prev_valid <= 1'b0;
         idx        <= '0;
         rd         <= '0;
         len        <= '0;
         seq        <= '0;
         csum       <= '0;
         err_count  <= '0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
         drain_live <= 1'b0;
      end else begin
         state      <= state_next;
         prev_valid <= word_valid_i;
         idx        <= idx_next;
         rd         <= rd_next;
         len        <= len_next;
         seq        <= seq_next;
         csum       <= csum_next;
         err_count  <= err_count_next;
         frame_ok   <= ok_next;
         frame_err  <= err_next;
         drain_live <= drain_live_next;
      end
   end

   // Next-state logic. drain_live holds out_valid low for the first DRAIN
   // cycle so the ok pulse precedes the first output word by one cycle.
   always_comb begin
      state_next      = state;
      idx_next        = idx;
      rd_next         = rd;
      len_next        = len;
      seq_next        = seq;
      csum_next       = csum;
      ok_next         = 1'b0;
      err_bump        = 1'b0;
      buf_wr          = 1'b0;
      drain_live_next = drain_live;

      case (state)
         HUNT: begin
            if (accept && (word_i[31:16] == SYNC)) begin
               if ((word_i[7:0] != 8'd0) && (word_i[7:0] <= MAX_LEN8)) begin
                  seq_next   = word_i[15:8];
                  len_next   = word_i[7:0];
                  csum_next  = word_i;
                  idx_next   = '0;
                  state_next = PAYLOAD;
               end else begin
                  err_bump = 1'b1;
               end
            end
         end

         PAYLOAD: begin
            if (accept) begin
               buf_wr    = 1'b1;
               csum_next = csum ^ word_i;
               idx_next  = idx + IDX_W'(1);
               if (8'(idx) == (len - 8'd1)) begin
                  state_next = CHECK;
               end
            end
         end

         CHECK: begin
            if (accept) begin
               if (word_i == csum) begin
                  ok_next         = 1'b1;
                  rd_next         = '0;
                  drain_live_next = 1'b0;
                  state_next      = DRAIN;
               end else begin
                  err_bump   = 1'b1;
                  state_next = HUNT;
               end
            end
         end

         DRAIN: begin
            drain_live_next = 1'b1;
            if (xfer) begin
               if (rd_is_last) begin
                  drain_live_next = 1'b0;
                  state_next      = HUNT;
               end else begin
                  rd_next = rd + IDX_W'(1);
               end
            end
            // Any word arriving now cannot be stored and is reported as an overrun
            if (accept) begin
               err_bump = 1'b1;
            end
         end

         default: begin
            state_next = HUNT;
         end
      endcase
   end

   // Error pulse and saturating counter share one bump strobe
   always_comb begin
      err_next       = err_bump;
      err_count_next = err_count;
      if (err_bump && (err_count != 8'hFF)) begin
         err_count_next = err_count + 8'd1;
      end
   end

   assign out_valid_o = (state == DRAIN) && drain_live;
   assign out_last_o  = out_valid_o && rd_is_last;
   assign out_data_o  = rd_data;
   assign out_seq_o   = seq;
   assign frame_ok_o  = frame_ok;
   assign frame_err_o = frame_err;
   assign err_count_o = err_count;

endmodule

// File: tb/tb_comm_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_comm_frame_parser
// Self-checking bench for comm_frame_parser. Frames are built from a
// frame-level description; the expected drained words, pulse counts and
// error count follow directly from whether each frame is good or bad.
// ---------------------------------------------------------------------------
module tb_comm_frame_parser;

   localparam logic [15:0] SYNC    = 16'hC0DE;
   localparam int          MAX_LEN = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        word_valid_i = 1'b0;
   logic [31:0] word_i = '0;
   logic        out_ready_i = 1'b1;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_last_o;
   logic [7:0]  out_seq_o;
   logic        frame_ok_o;
   logic        frame_err_o;
   logic [7:0]  err_count_o;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  seq;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   beat_t obs_q[$];
   beat_t stall_beat;
   logic  prev_stall = 1'b0;

   int checks = 0;
   int failures = 0;
   int ok_seen = 0;
   int err_seen = 0;
   int stall_events = 0;
   int stall_viol = 0;
   int exp_ok = 0;
   int exp_err = 0;
   int exp_errcnt = 0;
   int checked = 0;
   int ready_mode = 0;

   comm_frame_parser #(
      .SYNC    (SYNC),
      .MAX_LEN (MAX_LEN)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .word_valid_i (word_valid_i),
      .word_i       (word_i),
      .out_ready_i  (out_ready_i),
      .out_valid_o  (out_valid_o),
      .out_data_o   (out_data_o),
      .out_last_o   (out_last_o),
      .out_seq_o    (out_seq_o),
      .frame_ok_o   (frame_ok_o),
      .frame_err_o  (frame_err_o),
      .err_count_o  (err_count_o)
   );

   // 10 ns clock
   always #5 CLK = ~CLK;

   // Downstream ready: always, random, or held off, changed just after the edge
   always @(posedge CLK) begin
      #2;
      case (ready_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = 1'($urandom_range(0, 1));
         default: out_ready_i = 1'b0;
      endcase
   end

   // Monitor: counts pulses, collects accepted beats, watches stalled outputs
   always @(negedge CLK) begin
      if (frame_ok_o) ok_seen++;
      if (frame_err_o) err_seen++;
      if (prev_stall) begin
         stall_events++;
         if (!out_valid_o || out_data_o !== stall_beat.data ||
             out_seq_o !== stall_beat.seq || out_last_o !== stall_beat.last) begin
            stall_viol++;
         end
      end
      if (out_valid_o && out_ready_i) begin
         obs_q.push_back({out_data_o, out_seq_o, out_last_o});
      end
      prev_stall = out_valid_o && !out_ready_i && RST;
      stall_beat = {out_data_o, out_seq_o, out_last_o};
   end

   // Guard against a stuck run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one word as a rising level held for hold cycles, then drop it
   task automatic applyStimulus(input logic [31:0] w, input int hold);
      word_i       = w;
      word_valid_i = 1'b1;
      repeat (hold) @(negedge CLK);
      word_valid_i = 1'b0;
   endtask

   task automatic bump_err();
      exp_err++;
      if (exp_errcnt < 255) exp_errcnt++;
   endtask

   function automatic logic [31:0] junk_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:16] == SYNC) w[31:16] = ~SYNC;
      return w;
   endfunction

   // Full frame; a nonzero mask corrupts the checksum. Returns at the
   // falling edge just after the checksum word was accepted.
   task automatic frame(input logic [7:0] seq, input int len, input logic [31:0] mask,
                        input int hold, input bit rand_payload);
      logic [31:0] header;
      logic [31:0] csum;
      logic [31:0] w;
      header = {SYNC, seq, 8'(len)};
      csum   = header;
      applyStimulus(header, hold);
      for (int i = 0; i < len; i++) begin
         @(negedge CLK);
         w = rand_payload ? $urandom : 32'(i + 1);
         csum ^= w;
         applyStimulus(w, hold);
         if (mask == 32'd0) exp_q.push_back({w, seq, 1'(i == len - 1)});
      end
      @(negedge CLK);
      applyStimulus(csum ^ mask, hold);
      if (mask == 32'd0) exp_ok++;
      else bump_err();
   endtask

   task automatic bad_header(input logic [7:0] len, input int hold);
      applyStimulus({SYNC, 8'h77, len}, hold);
      bump_err();
      @(negedge CLK);
   endtask

   task automatic junk(input int hold);
      applyStimulus(junk_word(), hold);
      @(negedge CLK);
   endtask

   // Let any drain finish, then compare everything against the model
   task automatic check_progress(input string tag);
      for (int i = 0; i < 500 && obs_q.size() < exp_q.size(); i++) @(negedge CLK);
      repeat (3) @(negedge CLK);
      #1;
      checkOutput({tag, "_ok"}, ok_seen, exp_ok);
      checkOutput({tag, "_err"}, err_seen, exp_err);
      checkOutput({tag, "_errcnt"}, 32'(err_count_o), exp_errcnt);
      checkOutput({tag, "_beats"}, obs_q.size(), exp_q.size());
      for (int i = checked; i < exp_q.size() && i < obs_q.size(); i++) begin
         checkOutput({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         checkOutput({tag, "_seq"}, 32'(obs_q[i].seq), 32'(exp_q[i].seq));
         checkOutput({tag, "_last"}, 32'(obs_q[i].last), 32'(exp_q[i].last));
      end
      checked = exp_q.size();
   endtask

   // Directed sequence followed by a randomized section
   initial begin
      logic [31:0] held;
      int          kind;
      int          hold;
      int          len;

      repeat (3) @(negedge CLK);
      checkOutput("rst_valid", 32'(out_valid_o), 0);
      checkOutput("rst_last", 32'(out_last_o), 0);
      checkOutput("rst_ok", 32'(frame_ok_o), 0);
      checkOutput("rst_err", 32'(frame_err_o), 0);
      checkOutput("rst_errcnt", 32'(err_count_o), 0);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      $display("[TB] basic frame with latency checks");
      frame(8'h05, 3, 32'd0, 1, 1'b0);
      checkOutput("lat_ok", 32'(frame_ok_o), 1);
      checkOutput("lat_valid0", 32'(out_valid_o), 0);
      @(negedge CLK);
      checkOutput("lat_valid1", 32'(out_valid_o), 1);
      checkOutput("lat_ok_drop", 32'(frame_ok_o), 0);
      checkOutput("lat_data", out_data_o, 32'd1);
      checkOutput("lat_seq", 32'(out_seq_o), 32'h05);
      check_progress("basic");

      $display("[TB] zero checksum");
      frame(8'h05, 3, 32'hC0DE_0503, 1, 1'b0);
      check_progress("badcsum");

      $display("[TB] long valid level");
      frame(8'h37, 3, 32'd0, 40, 1'b1);
      check_progress("hold40");

      $display("[TB] bad lengths then good frame");
      bad_header(8'h09, 1);
      bad_header(8'h00, 1);
      frame(8'h38, MAX_LEN, 32'd0, 2, 1'b1);
      check_progress("badlen");

      $display("[TB] overrun while stalled");
      ready_mode = 2;
      frame(8'h39, 3, 32'd0, 1, 1'b1);
      repeat (3) @(negedge CLK);
      checkOutput("stall_valid", 32'(out_valid_o), 1);
      checkOutput("stall_data", out_data_o, exp_q[checked].data);
      held = out_data_o;
      applyStimulus(junk_word(), 1);
      bump_err();
      @(negedge CLK);
      checkOutput("ovr_errcnt", 32'(err_count_o), exp_errcnt);
      checkOutput("ovr_data", out_data_o, held);
      ready_mode = 0;
      check_progress("overrun");

      $display("[TB] overrun on final transfer");
      frame(8'h30, 1, 32'd0, 1, 1'b1);
      @(negedge CLK);
      checkOutput("fin_last", 32'(out_last_o), 1);
      applyStimulus(junk_word(), 1);
      bump_err();
      check_progress("finovr");

      $display("[TB] reset mid-frame");
      applyStimulus({SYNC, 8'h44, 8'd4}, 1);
      @(negedge CLK);
      applyStimulus($urandom, 1);
      @(negedge CLK);
      applyStimulus($urandom, 1);
      @(negedge CLK);
      RST = 1'b0;
      exp_errcnt = 0;
      @(negedge CLK);
      checkOutput("mid_rst_errcnt", 32'(err_count_o), 0);
      checkOutput("mid_rst_valid", 32'(out_valid_o), 0);
      RST = 1'b1;
      @(negedge CLK);
      frame(8'h45, 4, 32'd0, 1, 1'b1);
      check_progress("midrst");

      $display("[TB] randomized frames");
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         hold = $urandom_range(1, 3);
         repeat ($urandom_range(0, 2)) junk(hold);
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, MAX_LEN);
         if (kind <= 1) frame(8'($urandom), len, 32'd0, hold, 1'b1);
         else if (kind == 2) frame(8'($urandom), len, $urandom | 32'd1, hold, 1'b1);
         else bad_header(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255)), hold);
         check_progress("rand");
      end
      ready_mode = 0;
      checkOutput("stall_seen", 32'(stall_events > 0), 1);
      checkOutput("stall_stable", stall_viol, 0);

      $display("[TB] counter saturation");
      for (int n = 0; n < 260; n++) bad_header(8'd0, 1);
      check_progress("sat");
      checkOutput("sat_ff", 32'(err_count_o), 32'hFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
